// File: rtl/mem_write_checker.sv
// Self-check monitor for a data-memory write port: matches snooped stores against an ordered
// table of expected (address, data) pairs. Define CHECKER_LOG_EN to capture the failing write.
module mem_write_checker #(
    parameter int unsigned                 WIDTH          = 32,
    parameter int unsigned                 NUM_CHECKS     = 1,
    parameter logic [NUM_CHECKS*WIDTH-1:0] EXP_ADR        = (NUM_CHECKS*WIDTH)'(84),
    parameter logic [NUM_CHECKS*WIDTH-1:0] EXP_DATA       = (NUM_CHECKS*WIDTH)'(7),
    parameter logic [WIDTH-1:0]            SCRATCH_ADR    = WIDTH'(80),
    parameter bit                          STRICT         = 1'b1,
    parameter int unsigned                 TIMEOUT_CYCLES = 4096
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                memwrite,
    input  logic [WIDTH-1:0]                    dataadr,
    input  logic [WIDTH-1:0]                    writedata,
    output logic                                done,
    output logic                                pass,
    output logic                                fail,
    output logic [1:0]                          fail_code,
    output logic [$clog2(NUM_CHECKS+1)-1:0]     match_count,
    output logic [WIDTH-1:0]                    fail_adr,
    output logic [WIDTH-1:0]                    fail_data
);

    localparam int unsigned CW = $clog2(NUM_CHECKS + 1);
    localparam int unsigned TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] LastIdx   = CW'(NUM_CHECKS - 1);

    localparam logic [1:0] FcNone     = 2'd0;
    localparam logic [1:0] FcUnexpAdr = 2'd1;
    localparam logic [1:0] FcDataMis  = 2'd2;
    localparam logic [1:0] FcTimeout  = 2'd3;

    typedef enum logic [1:0] {StRun, StPass, StFail} state_e;

    state_e          state_q;
    logic [CW-1:0]   match_count_q;
    logic [TW-1:0]   timer_q;
    logic            done_q;
    logic            pass_q;
    logic            fail_q;
    logic [1:0]      fail_code_q;

    logic [WIDTH-1:0] cur_adr;
    logic [WIDTH-1:0] cur_data;

    // Select the table entry the next matching store must hit.
    always_comb begin
        cur_adr  = EXP_ADR[WIDTH-1:0];
        cur_data = EXP_DATA[WIDTH-1:0];
        for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
            if (match_count_q == CW'(i)) begin
                cur_adr  = EXP_ADR[i*WIDTH +: WIDTH];
                cur_data = EXP_DATA[i*WIDTH +: WIDTH];
            end
        end
    end

    logic adr_hit;
    logic scratch_hit;
    logic wr_match;
    logic wr_mismatch;
    logic wr_unexp;
    logic last_entry;
    logic expire;
    logic pass_now;
    logic fail_now;
    logic [1:0] fail_code_d;

    assign adr_hit     = memwrite && (dataadr == cur_adr);
    assign scratch_hit = memwrite && (dataadr == SCRATCH_ADR);
    assign wr_match    = adr_hit && (writedata == cur_data);
    assign wr_mismatch = adr_hit && (writedata != cur_data);
    // The expected-address compare shadows the scratch compare when both addresses coincide.
    assign wr_unexp    = STRICT && memwrite && !adr_hit && !scratch_hit;
    assign last_entry  = (match_count_q == LastIdx);
    assign expire      = (TIMEOUT_CYCLES != 0) && (timer_q == TimerLast);

    // A deciding write outranks a simultaneous watchdog expiry.
    always_comb begin
        pass_now    = wr_match && last_entry;
        fail_now    = 1'b0;
        fail_code_d = FcNone;
        if (!pass_now) begin
            if (wr_mismatch) begin
                fail_now    = 1'b1;
                fail_code_d = FcDataMis;
            end else if (wr_unexp) begin
                fail_now    = 1'b1;
                fail_code_d = FcUnexpAdr;
            end else if (expire) begin
                fail_now    = 1'b1;
                fail_code_d = FcTimeout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRun;
            match_count_q <= '0;
            timer_q       <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            fail_code_q   <= FcNone;
        end else begin
            case (state_q)
                StRun: begin
                    if (TIMEOUT_CYCLES != 0) begin
                        timer_q <= timer_q + TW'(1);
                    end
                    if (wr_match) begin
                        match_count_q <= match_count_q + CW'(1);
                    end
                    if (pass_now) begin
                        state_q <= StPass;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b1;
                    end else if (fail_now) begin
                        state_q     <= StFail;
                        done_q      <= 1'b1;
                        fail_q      <= 1'b1;
                        fail_code_q <= fail_code_d;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CHECKER_LOG_EN
    logic [WIDTH-1:0] fail_adr_q;
    logic [WIDTH-1:0] fail_data_q;

    // Timeouts leave the capture registers at their reset value of zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            fail_adr_q  <= '0;
            fail_data_q <= '0;
        end else if (state_q == StRun && fail_now && fail_code_d != FcTimeout) begin
            fail_adr_q  <= dataadr;
            fail_data_q <= writedata;
        end
    end

    assign fail_adr  = fail_adr_q;
    assign fail_data = fail_data_q;
`else
    assign fail_adr  = '0;
    assign fail_data = '0;
`endif

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign fail_code   = fail_code_q;
    assign match_count = match_count_q;

endmodule
